mpt_walker: RTL and testbench

Memory Protection Table walker stage. Accepts a physical-address access check from the upstream pipeline register over a valid/ready port. Walks a LEVELS-deep MPT in memory, one 64-bit entry read per level, and emits an allow/fault verdict on a downstream valid/ready port. It sits between the request-capture pipeline register and the result pipeline register of the MPT check pipeline.

---
 rtl/mpt_pkg.sv | 33 +++
 rtl/mpt_walker_if.sv | 11 +
 rtl/mpt_pte_decode.sv | 45 ++++
 rtl/mpt_walker.sv | 142 ++++++++++++++
 tb/tb_mpt_walker.sv | 448 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mpt_pkg.sv
// Shared types and entry bit positions for the memory-protection-table walker.
package mpt_pkg;

    typedef enum logic [1:0] {
        ACC_R    = 2'd0,
        ACC_W    = 2'd1,
        ACC_X    = 2'd2,
        ACC_RSVD = 2'd3
    } acc_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        DONE  = 3'd3,
        DRAIN = 3'd4
    } walk_state_e;

    localparam int PTE_V       = 0;
    localparam int PTE_L       = 1;
    localparam int PTE_R       = 2;
    localparam int PTE_W       = 3;
    localparam int PTE_X       = 4;
    localparam int PTE_PPN_LSB = 10;

    // Upper verdict fields; the physical address is appended below them.
    typedef struct packed {
        logic fault;
        logic allow;
        acc_e acc;
    } verdict_t;

endpackage

// File: rtl/mpt_walker_if.sv
// Generic valid/ready channel used for every handshake port of the walker.
interface mpt_walker_if #(
    parameter int W = 32
);
    logic         valid;
    logic         ready;
    logic [W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/mpt_pte_decode.sv
// Combinational decode of one table entry into descend/fault/allow and next-table PPN.
module mpt_pte_decode
    import mpt_pkg::*;
#(
    parameter int PPN_W = 18
) (
    input  logic [63:0]      pte,
    input  acc_e             acc,
    input  logic             last,
    output logic             descend,
    output logic             fault,
    output logic             allow,
    output logic [PPN_W-1:0] next_ppn
);
    logic perm;
    logic unused;

    // Only a handful of entry bits carry meaning; the rest are deliberately ignored.
    assign unused   = ^pte;
    assign next_ppn = pte[PTE_PPN_LSB +: PPN_W];

    always_comb begin
        case (acc)
            ACC_R:   perm = pte[PTE_R];
            ACC_W:   perm = pte[PTE_W];
            ACC_X:   perm = pte[PTE_X];
            default: perm = 1'b0;
        endcase
    end

    always_comb begin
        descend = 1'b0;
        fault   = 1'b1;
        allow   = 1'b0;
        if (pte[PTE_V]) begin
            if (pte[PTE_L]) begin
                fault = 1'b0;
                allow = perm;
            end else if (!last) begin
                descend = 1'b1;
                fault   = 1'b0;
            end
        end
    end
endmodule

// File: rtl/mpt_walker.sv
// MPT walker: one entry read per level, then an allow/fault verdict downstream.
module mpt_walker
    import mpt_pkg::*;
#(
    parameter  int LEVELS = 2,
    parameter  int IDX_W  = 9,
    localparam int PA_W   = 12 + LEVELS * IDX_W,
    localparam int PPN_W  = PA_W - 12,
    localparam int RES_W  = PA_W + 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [PPN_W-1:0] mptp_base_i,
    mpt_walker_if.slave      s_data,
    mpt_walker_if.master     m_data,
    mpt_walker_if.master     m_mem,
    mpt_walker_if.slave      s_rsp,
    input  logic             s_ctrl_flush,
    input  logic             s_ctrl_stall,
    output logic             s_status_busy
);
    localparam int               LVL_W    = (LEVELS > 1) ? $clog2(LEVELS) : 1;
    localparam logic [LVL_W-1:0] LAST_LVL = LVL_W'(LEVELS - 1);

    walk_state_e      state;
    logic [LVL_W-1:0] level;
    logic [PA_W-1:0]  pa;
    acc_e             acc;
    logic [PPN_W-1:0] table_ppn;
    logic             fault;
    logic             allow;

    logic [PA_W-1:0]  req_pa;
    acc_e             req_acc;
    logic [IDX_W-1:0] idx;
    logic             last_level;
    logic             pte_descend;
    logic             pte_fault;
    logic             pte_allow;
    logic [PPN_W-1:0] pte_ppn;
    verdict_t         verdict;
    logic             accept;
    logic             emit;
    logic             mem_fire;

    assign req_pa     = s_data.data[PA_W-1:0];
    assign req_acc    = acc_e'(s_data.data[PA_W +: 2]);
    assign idx        = pa[PA_W - 1 - int'(level) * IDX_W -: IDX_W];
    assign last_level = (level == LAST_LVL);

    mpt_pte_decode #(
        .PPN_W (PPN_W)
    ) u_decode (
        .pte      (s_rsp.data),
        .acc      (acc),
        .last     (last_level),
        .descend  (pte_descend),
        .fault    (pte_fault),
        .allow    (pte_allow),
        .next_ppn (pte_ppn)
    );

    // Handshake outputs come from registered state; only stall and reset gate them.
    assign s_data.ready  = (state == IDLE) && !s_ctrl_stall && !rst_i;
    assign m_data.valid  = (state == DONE) && !s_ctrl_stall && !rst_i;
    assign m_mem.valid   = (state == REQ) && !rst_i;
    assign m_mem.data    = {table_ppn, idx, 3'b000};
    assign s_rsp.ready   = 1'b1;
    assign verdict       = '{fault: fault, allow: allow, acc: acc};
    assign m_data.data   = {verdict, pa};
    assign s_status_busy = (state != IDLE);

    assign accept   = s_data.valid && s_data.ready;
    assign emit     = m_data.valid && m_data.ready;
    assign mem_fire = m_mem.valid && m_mem.ready;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            level     <= '0;
            pa        <= '0;
            acc       <= ACC_R;
            table_ppn <= '0;
            fault     <= 1'b0;
            allow     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && !s_ctrl_flush) begin
                        pa        <= req_pa;
                        acc       <= req_acc;
                        table_ppn <= mptp_base_i;
                        level     <= '0;
                        if (req_acc == ACC_RSVD) begin
                            fault <= 1'b1;
                            allow <= 1'b0;
                            state <= DONE;
                        end else begin
                            state <= REQ;
                        end
                    end
                end
                REQ: begin
                    // A read already handed to memory must have its response drained.
                    if (s_ctrl_flush) begin
                        state <= mem_fire ? DRAIN : IDLE;
                    end else if (mem_fire) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (s_rsp.valid) begin
                        if (s_ctrl_flush) begin
                            state <= IDLE;
                        end else if (pte_descend) begin
                            table_ppn <= pte_ppn;
                            level     <= level + 1'b1;
                            state     <= REQ;
                        end else begin
                            fault <= pte_fault;
                            allow <= pte_allow;
                            state <= DONE;
                        end
                    end else if (s_ctrl_flush) begin
                        state <= DRAIN;
                    end
                end
                DONE: begin
                    if (s_ctrl_flush || emit) begin
                        state <= IDLE;
                    end
                end
                DRAIN: begin
                    if (s_rsp.valid) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mpt_walker.sv
// Self-checking bench for mpt_walker: memory responder, verdict scoreboard, scenario tasks.
module tb_mpt_walker;
    import mpt_pkg::*;

    localparam int LEVELS = 2;
    localparam int IDX_W  = 9;
    localparam int PA_W   = 12 + LEVELS * IDX_W;
    localparam int PPN_W  = PA_W - 12;
    localparam int RES_W  = PA_W + 4;

    typedef struct {
        logic [RES_W-1:0] res;
        int               lat;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [PPN_W-1:0] mptp_base = 18'd2;
    logic             flush = 1'b0;
    logic             stall = 1'b0;
    logic             busy;

    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;
    int last_acc_cyc = 0;

    logic [63:0]     mem [logic [PA_W-1:0]];
    exp_t            exp_q[$];
    logic [PA_W-1:0] exp_addr_q[$];
    logic [PA_W-1:0] rd_log[$];

    int              rsp_delay = 1;
    int              rsp_cnt = 0;
    logic [PA_W-1:0] rsp_addr = '0;
    bit              inject = 1'b0;

    mpt_walker_if #(.W(PA_W + 2)) s_data ();
    mpt_walker_if #(.W(RES_W))    m_data ();
    mpt_walker_if #(.W(PA_W))     m_mem ();
    mpt_walker_if #(.W(64))       s_rsp ();

    mpt_walker #(
        .LEVELS (LEVELS),
        .IDX_W  (IDX_W)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .mptp_base_i   (mptp_base),
        .s_data        (s_data),
        .m_data        (m_data),
        .m_mem         (m_mem),
        .s_rsp         (s_rsp),
        .s_ctrl_flush  (flush),
        .s_ctrl_stall  (stall),
        .s_status_busy (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory: answers each accepted read rsp_delay cycles later; can inject a stray response.
    initial begin
        s_rsp.valid = 1'b0;
        s_rsp.data  = '0;
        forever begin
            @(negedge clk);
            s_rsp.valid = 1'b0;
            if (rsp_cnt > 0) begin
                rsp_cnt--;
                if (rsp_cnt == 0) begin
                    s_rsp.valid = 1'b1;
                    s_rsp.data  = mem.exists(rsp_addr) ? mem[rsp_addr] : 64'd0;
                end
            end
            if (inject) begin
                s_rsp.valid = 1'b1;
                s_rsp.data  = 64'h7;
                inject      = 1'b0;
            end
            if (m_mem.valid && m_mem.ready) begin
                rd_log.push_back(m_mem.data);
                rsp_addr = m_mem.data;
                rsp_cnt  = rsp_delay;
            end
        end
    end

    // Scoreboard: every emitted verdict is compared with the oldest expectation.
    initial begin
        exp_t e;
        bit   bad;
        int   rel;
        forever begin
            @(negedge clk);
            if (!rst && m_data.valid && m_data.ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_verdict: got %h, required no verdict", m_data.data);
                end else begin
                    e = exp_q.pop_front();
                    if (m_data.data !== e.res)
                        $display("FAIL verdict: got %h, required %h", m_data.data, e.res);
                    else
                        n_pass++;
                    if (e.lat > 0) begin
                        rel = cyc - last_acc_cyc + 1;
                        n_checks++;
                        if (rel !== e.lat)
                            $display("FAIL latency: got cycle %0d, required cycle %0d", rel, e.lat);
                        else
                            n_pass++;
                    end
                    bad = (rd_log.size() != exp_addr_q.size());
                    if (!bad)
                        foreach (rd_log[i]) if (rd_log[i] !== exp_addr_q[i]) bad = 1'b1;
                    n_checks++;
                    if (bad)
                        $display("FAIL read_addrs: got %0d reads (first %h), required %0d reads (first %h)",
                                 rd_log.size(), (rd_log.size() > 0) ? rd_log[0] : '0,
                                 exp_addr_q.size(), (exp_addr_q.size() > 0) ? exp_addr_q[0] : '0);
                    else
                        n_pass++;
                end
                rd_log.delete();
                exp_addr_q.delete();
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1, "watchdog");
    end

    function automatic void model(input logic [PA_W-1:0] pa, input logic [1:0] acc, input bit chk_lat);
        logic [PPN_W-1:0] ppn;
        logic             f, a, stop;
        int               reads;
        logic [63:0]      e;
        logic [PA_W-1:0]  ad;
        ppn = mptp_base; f = 1'b1; a = 1'b0; reads = 0; stop = 1'b0;
        if (acc != 2'd3) begin
            for (int l = 0; l < LEVELS; l++) begin
                if (!stop) begin
                    ad = {ppn, pa[PA_W-1-l*IDX_W -: IDX_W], 3'b000};
                    exp_addr_q.push_back(ad);
                    reads++;
                    e = mem.exists(ad) ? mem[ad] : 64'd0;
                    if (!e[0]) begin
                        stop = 1'b1;
                    end else if (e[1]) begin
                        f = 1'b0;
                        a = (acc == 2'd0) ? e[2] : (acc == 2'd1) ? e[3] : e[4];
                        stop = 1'b1;
                    end else begin
                        ppn = e[10 +: PPN_W];
                    end
                end
            end
        end
        exp_q.push_back('{res: {f, a, acc, pa}, lat: chk_lat ? 1 + 2 * reads : 0});
    endfunction

    task automatic send_req(input logic [PA_W-1:0] pa, input logic [1:0] acc, output bit ok);
        s_data.valid = 1'b1;
        s_data.data  = {acc, pa};
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (s_data.ready) begin
                ok = 1'b1;
                last_acc_cyc = cyc + 1;
                break;
            end
        end
        @(posedge clk); #1;
        s_data.valid = 1'b0;
    endtask

    task automatic wait_done(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (m_data.valid && m_data.ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        repeat (2) begin
            @(negedge clk);
            n_checks++;
            if (s_data.ready !== 1'b0) $display("FAIL rst_s_ready: got %b, required 0", s_data.ready);
            else n_pass++;
            n_checks++;
            if (m_data.valid !== 1'b0) $display("FAIL rst_m_valid: got %b, required 0", m_data.valid);
            else n_pass++;
            n_checks++;
            if (m_mem.valid !== 1'b0) $display("FAIL rst_mem_valid: got %b, required 0", m_mem.valid);
            else n_pass++;
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) $display("FAIL rst_busy: got %b, required 0", busy);
        else n_pass++;
        n_checks++;
        if (s_data.ready !== 1'b1) $display("FAIL idle_ready: got %b, required 1", s_data.ready);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_walk_allow();
        bit ok;
        model(30'h0040_1000, 2'd0, 1'b1);
        send_req(30'h0040_1000, 2'd0, ok);
        @(negedge clk);
        n_checks++;
        if (m_mem.valid !== 1'b1 || m_mem.data !== 30'h2010)
            $display("FAIL root_addr: got v=%b a=%h, required v=1 a=%h", m_mem.valid, m_mem.data, 30'h2010);
        else n_pass++;
        repeat (2) @(negedge clk);
        n_checks++;
        if (m_mem.valid !== 1'b1 || m_mem.data !== 30'h1008)
            $display("FAIL leaf_addr: got v=%b a=%h, required v=1 a=%h", m_mem.valid, m_mem.data, 30'h1008);
        else n_pass++;
        wait_done(20, ok);
        n_checks++;
        if (!ok) $display("FAIL allow_done: got no verdict, required a verdict");
        else n_pass++;
    endtask

    task automatic test_perm_and_reserved();
        bit ok;
        logic [PA_W-1:0] pas [3] = '{30'h0040_1000, 30'h0040_2000, 30'h0040_1000};
        logic [1:0]      accs[3] = '{2'd1, 2'd2, 2'd3};
        for (int k = 0; k < 3; k++) begin
            model(pas[k], accs[k], 1'b1);
            send_req(pas[k], accs[k], ok);
            wait_done(20, ok);
            n_checks++;
            if (!ok) $display("FAIL perm_done_%0d: got no verdict, required a verdict", k);
            else n_pass++;
        end
    endtask

    task automatic test_faults();
        bit ok;
        logic [PA_W-1:0] pas [2] = '{30'h0060_0000, 30'h0080_0000};
        for (int k = 0; k < 2; k++) begin
            model(pas[k], 2'd0, 1'b1);
            send_req(pas[k], 2'd0, ok);
            wait_done(20, ok);
            n_checks++;
            if (!ok) $display("FAIL fault_done_%0d: got no verdict, required a verdict", k);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        bit seen;
        logic [RES_W-1:0] want;
        want = {1'b0, 1'b1, 2'd0, 30'h0040_1000};
        m_mem.ready  = 1'b0;
        m_data.ready = 1'b0;
        model(30'h0040_1000, 2'd0, 1'b0);
        send_req(30'h0040_1000, 2'd0, ok);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (m_mem.valid !== 1'b1 || m_mem.data !== 30'h2010)
                $display("FAIL mem_hold_%0d: got v=%b a=%h, required v=1 a=%h", i, m_mem.valid, m_mem.data, 30'h2010);
            else n_pass++;
        end
        @(posedge clk); #1;
        m_mem.ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m_data.valid) begin
                seen = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!seen) $display("FAIL bp_verdict: got no m_data_valid, required m_data_valid");
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            n_checks++;
            if (m_data.valid !== 1'b1 || m_data.data !== want)
                $display("FAIL verdict_hold_%0d: got v=%b d=%h, required v=1 d=%h", i, m_data.valid, m_data.data, want);
            else n_pass++;
            n_checks++;
            if (s_data.ready !== 1'b0) $display("FAIL busy_ready_%0d: got %b, required 0", i, s_data.ready);
            else n_pass++;
        end
        @(posedge clk); #1;
        m_data.ready = 1'b1;
        wait_done(5, ok);
        n_checks++;
        if (!ok) $display("FAIL bp_done: got no handshake, required handshake");
        else n_pass++;
    endtask

    task automatic test_flush_and_stall();
        bit ok;
        bit bad;
        rsp_delay = 3;
        send_req(30'h0040_1000, 2'd0, ok);
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1 || m_mem.valid !== 1'b0 || m_data.valid !== 1'b0 || s_data.ready !== 1'b0)
            $display("FAIL drain_outputs: got busy=%b mv=%b dv=%b rdy=%b, required 1 0 0 0",
                     busy, m_mem.valid, m_data.valid, s_data.ready);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) $display("FAIL drain_wait: got busy=%b, required 1", busy);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || s_data.ready !== 1'b1)
            $display("FAIL drain_exit: got busy=%b rdy=%b, required 0 1", busy, s_data.ready);
        else n_pass++;
        bad = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (m_data.valid !== 1'b0) bad = 1'b1;
        end
        n_checks++;
        if (bad) $display("FAIL flush_no_verdict: got m_data_valid=1, required 0");
        else n_pass++;
        @(posedge clk); #1;
        rsp_delay = 1;
        rd_log.delete();

        model(30'h0040_2000, 2'd2, 1'b0);
        send_req(30'h0040_2000, 2'd2, ok);
        stall = 1'b1;
        bad = 1'b0;
        repeat (7) begin
            @(negedge clk);
            if (m_data.valid !== 1'b0) bad = 1'b1;
        end
        n_checks++;
        if (bad) $display("FAIL stall_emit: got m_data_valid=1, required 0");
        else n_pass++;
        n_checks++;
        if (busy !== 1'b1 || m_mem.valid !== 1'b0)
            $display("FAIL stall_done: got busy=%b mv=%b, required 1 0", busy, m_mem.valid);
        else n_pass++;
        @(posedge clk); #1;
        stall = 1'b0;
        wait_done(5, ok);
        n_checks++;
        if (!ok) $display("FAIL stall_release: got no verdict, required a verdict");
        else n_pass++;
        stall = 1'b1;
        @(negedge clk);
        n_checks++;
        if (s_data.ready !== 1'b0) $display("FAIL stall_accept: got %b, required 0", s_data.ready);
        else n_pass++;
        @(posedge clk); #1;
        stall = 1'b0;
    endtask

    task automatic test_reset_midwalk();
        bit ok;
        bit bad;
        m_mem.ready = 1'b0;
        send_req(30'h0040_1000, 2'd0, ok);
        @(negedge clk);
        n_checks++;
        if (m_mem.valid !== 1'b1 || busy !== 1'b1)
            $display("FAIL req_state: got mv=%b busy=%b, required 1 1", m_mem.valid, busy);
        else n_pass++;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (m_mem.valid !== 1'b0) $display("FAIL rst_gate_mem: got %b, required 0", m_mem.valid);
        else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || m_mem.valid !== 1'b0 || m_data.valid !== 1'b0 || s_data.ready !== 1'b1)
            $display("FAIL post_rst: got busy=%b mv=%b dv=%b rdy=%b, required 0 0 0 1",
                     busy, m_mem.valid, m_data.valid, s_data.ready);
        else n_pass++;
        @(posedge clk); #1;
        m_mem.ready = 1'b1;
        inject = 1'b1;
        bad = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (busy !== 1'b0 || m_data.valid !== 1'b0 || m_mem.valid !== 1'b0) bad = 1'b1;
        end
        n_checks++;
        if (bad) $display("FAIL stale_rsp: got activity after stale response, required none");
        else n_pass++;
        n_checks++;
        if (rd_log.size() !== 0) $display("FAIL rst_reads: got %0d reads, required 0", rd_log.size());
        else n_pass++;
        @(posedge clk); #1;
    endtask

    initial begin
        s_data.valid = 1'b0;
        s_data.data  = '0;
        m_data.ready = 1'b1;
        m_mem.ready  = 1'b1;
        mem[30'h2010] = 64'hA000_0000_0000_07E1;
        mem[30'h1008] = 64'h07;
        mem[30'h1010] = 64'h13;
        mem[30'h2018] = 64'h0;
        mem[30'h2020] = 64'h801;
        mem[30'h2000] = 64'h401;

        test_reset();
        test_walk_allow();
        test_perm_and_reserved();
        test_faults();
        test_backpressure();
        test_flush_and_stall();
        test_reset_midwalk();

        repeat (2) @(negedge clk);
        n_checks++;
        if (exp_q.size() !== 0) $display("FAIL leftover_expect: got %0d pending, required 0", exp_q.size());
        else n_pass++;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
